// File: rtl/br_cam.sv
// br_cam: content-addressable packet table keyed on {source, id} with aging,
// duplicate detection, clear and one-cycle lookup.
//   clk_i, rst_i                      clock, synchronous active-high reset
//   ins_valid_i/ins_ready_o           insert handshake; ready = a free entry exists
//   ins_source_i/ins_id_i             insert key
//   ins_svc_i/ins_port_i              stored service (ALL/TGT/CLEAR) and arrival port
//   ins_dup_o                         pulse: insert hit a live entry (age refreshed)
//   lkp_valid_i/lkp_source_i/lkp_id_i lookup request and key
//   lkp_done_o/lkp_hit_o/lkp_idx_o/lkp_port_o  lookup result, one cycle later
//   clr_valid_i/clr_source_i/clr_id_i free the entry holding the key
//   count_o                           live entry count
//   evict_o                           pulse: an entry aged out
module br_cam #(
    parameter int DEPTH     = 8,
    parameter int ID_WIDTH  = 5,
    parameter int SRC_WIDTH = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ins_valid_i,
    output logic                         ins_ready_o,
    input  logic [SRC_WIDTH-1:0]         ins_source_i,
    input  logic [ID_WIDTH-1:0]          ins_id_i,
    input  logic [1:0]                   ins_svc_i,
    input  logic [2:0]                   ins_port_i,
    output logic                         ins_dup_o,
    input  logic                         lkp_valid_i,
    input  logic [SRC_WIDTH-1:0]         lkp_source_i,
    input  logic [ID_WIDTH-1:0]          lkp_id_i,
    output logic                         lkp_done_o,
    output logic                         lkp_hit_o,
    output logic [$clog2(DEPTH)-1:0]     lkp_idx_o,
    output logic [2:0]                   lkp_port_o,
    input  logic                         clr_valid_i,
    input  logic [SRC_WIDTH-1:0]         clr_source_i,
    input  logic [ID_WIDTH-1:0]          clr_id_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         evict_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(TIMEOUT + 1);
    localparam int KW = SRC_WIDTH + ID_WIDTH;
    localparam logic [1:0]    SVC_CLEAR = 2'd2;
    localparam logic [AW-1:0] AGE_MAX   = AW'(TIMEOUT);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [KW-1:0]    key_q  [DEPTH];
    logic [1:0]       svc_q  [DEPTH];
    logic [2:0]       port_q [DEPTH];
    logic [AW-1:0]    age_q  [DEPTH];
    logic [AW-1:0]    age_d  [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, dup_q, done_q, hit_q, evict_q;
    logic [IW-1:0]    idx_q;
    logic [2:0]       lport_q;

    logic [KW-1:0]    ins_key, lkp_key, clr_key;
    logic [DEPTH-1:0] ins_m, lkp_m, clr_m, expire, refresh, kill, write;
    logic             ins_hit, lkp_hit, ins_acc;
    logic [IW-1:0]    free_idx, lkp_idx;

    assign ins_key = {ins_source_i, ins_id_i};
    assign lkp_key = {lkp_source_i, lkp_id_i};
    assign clr_key = {clr_source_i, clr_id_i};
    assign ins_hit = |ins_m;
    assign lkp_hit = |lkp_m;
    // A same-cycle clear of the insert key wins, even when the clear matches nothing.
    assign ins_acc = ins_valid_i && ready_q && !ins_hit && !(clr_valid_i && clr_key == ins_key);

    // Lowest-index free slot and lowest-index lookup match, both from pre-update state.
    always_comb begin
        free_idx = '0;
        lkp_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx = !valid_q[i] ? IW'(i) : free_idx;
            lkp_idx  = lkp_m[i] ? IW'(i) : lkp_idx;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ins_m[i]   = valid_q[i] && key_q[i] == ins_key;
        assign lkp_m[i]   = valid_q[i] && key_q[i] == lkp_key;
        assign clr_m[i]   = valid_q[i] && key_q[i] == clr_key;
        assign expire[i]  = valid_q[i] && svc_q[i] != SVC_CLEAR && age_q[i] == AW'(1);
        assign refresh[i] = ins_valid_i && ins_m[i];
        assign kill[i]    = clr_valid_i && clr_m[i];
        assign write[i]   = ins_acc && free_idx == IW'(i);
        // A dup refresh rescues an entry that would expire this cycle; a clear beats both.
        assign valid_d[i] = write[i] || (valid_q[i] && !kill[i] && (!expire[i] || refresh[i]));
        assign age_d[i]   = !valid_d[i] ? '0 :
                            (write[i] || refresh[i]) ? AGE_MAX :
                            (svc_q[i] != SVC_CLEAR && age_q[i] != '0) ? age_q[i] - AW'(1) :
                            age_q[i];
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(valid_d[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            dup_q   <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            lport_q <= '0;
            evict_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            ready_q <= count_d != CW'(DEPTH);
            dup_q   <= ins_valid_i && ins_hit;
            done_q  <= lkp_valid_i;
            hit_q   <= lkp_valid_i && lkp_hit;
            idx_q   <= (lkp_valid_i && lkp_hit) ? lkp_idx : '0;
            lport_q <= (lkp_valid_i && lkp_hit) ? port_q[lkp_idx] : '0;
            evict_q <= |(expire & ~refresh);
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

    // Payload is only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write[i]) begin
                key_q[i]  <= ins_key;
                svc_q[i]  <= ins_svc_i;
                port_q[i] <= ins_port_i;
            end
        end
    end

    assign ins_ready_o = ready_q;
    assign count_o     = count_q;
    assign ins_dup_o   = dup_q;
    assign lkp_done_o  = done_q;
    assign lkp_hit_o   = hit_q;
    assign lkp_idx_o   = idx_q;
    assign lkp_port_o  = lport_q;
    assign evict_o     = evict_q;
endmodule

// File: tb/tb_br_cam.sv
// tb_br_cam: scoreboard bench for br_cam (DEPTH=8, TIMEOUT=4).
module tb_br_cam;
    localparam int DEPTH = 8;
    localparam int IDW   = 5;
    localparam int SW    = 16;
    localparam int TO    = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           ins_valid_i, ins_ready_o, ins_dup_o;
    logic [SW-1:0]  ins_source_i, lkp_source_i, clr_source_i;
    logic [IDW-1:0] ins_id_i, lkp_id_i, clr_id_i;
    logic [1:0]     ins_svc_i;
    logic [2:0]     ins_port_i, lkp_port_o;
    logic           lkp_valid_i, lkp_done_o, lkp_hit_o, clr_valid_i, evict_o;
    logic [2:0]     lkp_idx_o;
    logic [3:0]     count_o;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [2:0] port;
    } lkp_t;

    lkp_t lkp_q[$];
    int   dup_q[$];
    int   ev_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    br_cam #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .SRC_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o),
        .ins_source_i(ins_source_i), .ins_id_i(ins_id_i),
        .ins_svc_i(ins_svc_i), .ins_port_i(ins_port_i), .ins_dup_o(ins_dup_o),
        .lkp_valid_i(lkp_valid_i), .lkp_source_i(lkp_source_i), .lkp_id_i(lkp_id_i),
        .lkp_done_o(lkp_done_o), .lkp_hit_o(lkp_hit_o), .lkp_idx_o(lkp_idx_o),
        .lkp_port_o(lkp_port_o),
        .clr_valid_i(clr_valid_i), .clr_source_i(clr_source_i), .clr_id_i(clr_id_i),
        .count_o(count_o), .evict_o(evict_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (lkp_done_o) begin
            if (lkp_q.size() == 0) chk("lkp_unexpected", 1, 0);
            else begin
                lkp_t e;
                e = lkp_q.pop_front();
                chk("lkp_hit", int'(lkp_hit_o), int'(e.hit));
                chk("lkp_idx", int'(lkp_idx_o), int'(e.idx));
                chk("lkp_port", int'(lkp_port_o), int'(e.port));
            end
        end
        if (ins_dup_o) begin
            if (dup_q.size() == 0) chk("dup_unexpected", 1, 0);
            else chk("dup_cycle", cyc, dup_q.pop_front());
        end
        if (evict_o) begin
            if (ev_q.size() == 0) chk("evict_unexpected", 1, 0);
            else chk("evict_cycle", cyc, ev_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        ins_valid_i = 1'b0;
        lkp_valid_i = 1'b0;
        clr_valid_i = 1'b0;
    endtask

    task automatic ins(input int s, input int id, input int svc, input int port);
        ins_valid_i  = 1'b1;
        ins_source_i = SW'(s);
        ins_id_i     = IDW'(id);
        ins_svc_i    = 2'(svc);
        ins_port_i   = 3'(port);
    endtask

    task automatic clr(input int s, input int id);
        clr_valid_i  = 1'b1;
        clr_source_i = SW'(s);
        clr_id_i     = IDW'(id);
    endtask

    task automatic lkp(input int s, input int id, input int h, input int idx, input int port);
        lkp_t e;
        lkp_valid_i  = 1'b1;
        lkp_source_i = SW'(s);
        lkp_id_i     = IDW'(id);
        e.hit  = 1'(h);
        e.idx  = 3'(idx);
        e.port = 3'(port);
        lkp_q.push_back(e);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        ins_valid_i = 0; lkp_valid_i = 0; clr_valid_i = 0;
        ins_source_i = 0; ins_id_i = 0; ins_svc_i = 0; ins_port_i = 0;
        lkp_source_i = 0; lkp_id_i = 0; clr_source_i = 0; clr_id_i = 0;
        step();
        step();
        chk("rst_ready", int'(ins_ready_o), 1);
        chk("rst_count", int'(count_o), 0);
        chk("rst_pulses", int'({ins_dup_o, lkp_done_o, evict_o}), 0);
        chk("rst_lkp", int'({lkp_hit_o, lkp_idx_o, lkp_port_o}), 0);
        rst = 1'b0;

        // Basic insert and lookup, then natural aging to eviction.
        c = cyc;
        ins(16'h0101, 3, 0, 0);
        ev_q.push_back(c + 5);
        step();
        chk("t1_count", int'(count_o), 1);
        lkp(16'h0101, 3, 1, 0, 0);
        step();
        step();
        step();
        chk("t1_count_before_evict", int'(count_o), 1);
        step();
        chk("t1_count_after_evict", int'(count_o), 0);
        lkp(16'h0101, 3, 0, 0, 0);
        step();

        // Duplicate insert refreshes the age.
        c = cyc;
        ins(16'h0202, 1, 0, 2);
        step();
        step();
        ins(16'h0202, 1, 0, 2);
        dup_q.push_back(c + 3);
        ev_q.push_back(c + 7);
        step();
        chk("t2_count_dup", int'(count_o), 1);
        step();
        step();
        step();
        chk("t2_count_refreshed", int'(count_o), 1);
        step();
        chk("t2_count_evicted", int'(count_o), 0);

        // Same-cycle insert and clear of one key on an empty table.
        ins(16'h0303, 5, 0, 1);
        clr(16'h0303, 5);
        step();
        chk("t3_count", int'(count_o), 0);
        lkp(16'h0303, 5, 0, 0, 0);
        step();

        // CLEAR-service entry never ages.
        ins(16'h0404, 7, 2, 4);
        step();
        repeat (100) step();
        chk("t4_count_persist", int'(count_o), 1);
        lkp(16'h0404, 7, 1, 0, 4);
        step();
        clr(16'h0404, 7);
        step();
        chk("t4_count_cleared", int'(count_o), 0);

        // Fill the table, drop on full, slot freed by clear is reusable only next cycle.
        for (int i = 0; i < DEPTH; i++) begin
            ins(16'h1000 + i, i, 2, i % 5);
            step();
        end
        chk("t5_count_full", int'(count_o), 8);
        chk("t5_ready_full", int'(ins_ready_o), 0);
        ins(16'h2000, 9, 2, 1);
        step();
        chk("t5_count_drop", int'(count_o), 8);
        lkp(16'h2000, 9, 0, 0, 0);
        step();
        clr(16'h1002, 2);
        ins(16'h3000, 10, 2, 3);
        step();
        chk("t5_count_clr", int'(count_o), 7);
        chk("t5_ready_clr", int'(ins_ready_o), 1);
        lkp(16'h3000, 10, 0, 0, 0);
        step();
        ins(16'h3000, 10, 2, 3);
        step();
        chk("t5_count_refill", int'(count_o), 8);
        lkp(16'h3000, 10, 1, 2, 3);
        step();
        lkp(16'h1006, 6, 1, 6, 1);
        step();

        // Reset with live entries and a lookup in the same cycle.
        rst = 1'b1;
        lkp_valid_i  = 1'b1;
        lkp_source_i = 16'h1005;
        lkp_id_i     = 5'd5;
        step();
        chk("t6_done", int'(lkp_done_o), 0);
        chk("t6_count", int'(count_o), 0);
        chk("t6_ready", int'(ins_ready_o), 1);
        rst = 1'b0;
        lkp(16'h1005, 5, 0, 0, 0);
        step();
        step();
        chk("lkp_q_drained", lkp_q.size(), 0);
        chk("dup_q_drained", dup_q.size(), 0);
        chk("ev_q_drained", ev_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
